// File: rtl/traffic_light_fsm_pkg.sv
// Shared types and constants for the intersection sequencer.
// State codes, interval selects and lamp patterns.
package tl_pkg;

    typedef enum logic [2:0] {
        MAIN_G1 = 3'd0,
        MAIN_G2 = 3'd1,
        MAIN_Y  = 3'd2,
        WALK    = 3'd3,
        SIDE_G1 = 3'd4,
        SIDE_G2 = 3'd5,
        SIDE_Y  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SEL_BASE = 2'b00,
        SEL_EXT  = 2'b01,
        SEL_YEL  = 2'b10,
        SEL_NONE = 2'b11
    } sel_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    function automatic logic [2:0] main_of(state_t s);
        logic [2:0] l;
        l = RED;
        unique case (s)
            MAIN_G1, MAIN_G2: l = GRN;
            MAIN_Y:           l = YEL;
            default:          l = RED;
        endcase
        return l;
    endfunction

    function automatic logic [2:0] side_of(state_t s);
        logic [2:0] l;
        l = RED;
        unique case (s)
            SIDE_G1, SIDE_G2: l = GRN;
            SIDE_Y:           l = YEL;
            default:          l = RED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_light_fsm_if.sv
// Interval-timer link: load/start pulse with value out,
// one-cycle expiry pulse back.
interface traffic_light_fsm_if;

    logic       start_timer;
    logic [3:0] timer_value;
    logic       timer_expired;

    modport master (
        output start_timer,
        output timer_value,
        input  timer_expired
    );

    modport slave (
        input  start_timer,
        input  timer_value,
        output timer_expired
    );

endinterface

// File: rtl/traffic_light_fsm_param_regs.sv
// Programmable BASE/EXT/YEL interval registers.
// Zero writes clamp to 1 so the timer never wraps to 16 s.
module tl_param_regs
    import tl_pkg::*;
#(
    parameter logic [3:0] BASE_DEFAULT = 4'd6,
    parameter logic [3:0] EXT_DEFAULT  = 4'd3,
    parameter logic [3:0] YEL_DEFAULT  = 4'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       prog_en,
    input  logic [1:0] prog_sel,
    input  logic [3:0] prog_value,
    input  sel_t       sel,
    output logic [3:0] value
);

    logic [3:0] base_q;
    logic [3:0] ext_q;
    logic [3:0] yel_q;
    logic [3:0] clamped;

    assign clamped = (prog_value == 4'd0) ? 4'd1 : prog_value;

    // Register update on a write strobe; select 11 is a no-op.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= BASE_DEFAULT;
            ext_q  <= EXT_DEFAULT;
            yel_q  <= YEL_DEFAULT;
        end else if (prog_en) begin
            unique case (sel_t'(prog_sel))
                SEL_BASE: base_q <= clamped;
                SEL_EXT:  ext_q  <= clamped;
                SEL_YEL:  yel_q  <= clamped;
                default:  ;
            endcase
        end
    end

    // Current (pre-write) value of the requested interval.
    always_comb begin
        value = base_q;
        unique case (sel)
            SEL_EXT: value = ext_q;
            SEL_YEL: value = yel_q;
            default: value = base_q;
        endcase
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// Intersection sequencer: steps lights on timer expiry,
// loads the next interval and pulses the timer start.
module traffic_light_fsm
    import tl_pkg::*;
#(
    parameter logic [3:0] BASE_DEFAULT = 4'd6,
    parameter logic [3:0] EXT_DEFAULT  = 4'd3,
    parameter logic [3:0] YEL_DEFAULT  = 4'd2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sensor,
    input  logic                       walk_request,
    input  logic                       prog_en,
    input  logic [1:0]                 prog_sel,
    input  logic [3:0]                 prog_value,
    traffic_light_fsm_if.master        tmr,
    output logic [2:0]                 main_light,
    output logic [2:0]                 side_light,
    output logic                       walk_lamp,
    output logic [2:0]                 state_dbg
);

    state_t     state;
    state_t     next_state;
    sel_t       load_sel;
    logic [3:0] load_value;
    logic       walk_pending;
    logic       start_pending;
    logic       accept;

    tl_param_regs #(
        .BASE_DEFAULT (BASE_DEFAULT),
        .EXT_DEFAULT  (EXT_DEFAULT),
        .YEL_DEFAULT  (YEL_DEFAULT)
    ) u_params (
        .clk        (clk),
        .reset      (reset),
        .prog_en    (prog_en),
        .prog_sel   (prog_sel),
        .prog_value (prog_value),
        .sel        (load_sel),
        .value      (load_value)
    );

    assign state_dbg = state;

    // Successor and interval to load, assuming this cycle's expiry is taken.
    always_comb begin
        accept     = tmr.timer_expired && !tmr.start_timer
                     && !start_pending;
        next_state = state;
        load_sel   = SEL_BASE;
        unique case (state)
            MAIN_G1: begin
                next_state = MAIN_G2;
                load_sel   = sensor ? SEL_EXT : SEL_BASE;
            end
            MAIN_G2: begin
                next_state = MAIN_Y;
                load_sel   = SEL_YEL;
            end
            MAIN_Y: begin
                next_state = walk_pending ? WALK : SIDE_G1;
                load_sel   = walk_pending ? SEL_EXT : SEL_BASE;
            end
            WALK: begin
                next_state = SIDE_G1;
                load_sel   = SEL_BASE;
            end
            SIDE_G1: begin
                next_state = sensor ? SIDE_G2 : SIDE_Y;
                load_sel   = sensor ? SEL_EXT : SEL_YEL;
            end
            SIDE_G2: begin
                next_state = SIDE_Y;
                load_sel   = SEL_YEL;
            end
            SIDE_Y: begin
                next_state = MAIN_G1;
                load_sel   = SEL_BASE;
            end
            default: begin
                next_state = MAIN_G1;
                load_sel   = SEL_BASE;
            end
        endcase
        if (start_pending) begin
            load_sel = SEL_BASE;
        end
    end

    // State, lamps, timer load and walk latch, all registered together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= MAIN_G1;
            walk_pending    <= 1'b0;
            start_pending   <= 1'b1;
            tmr.start_timer <= 1'b0;
            tmr.timer_value <= BASE_DEFAULT;
            main_light      <= GRN;
            side_light      <= RED;
            walk_lamp       <= 1'b0;
        end else begin
            start_pending   <= 1'b0;
            tmr.start_timer <= accept || start_pending;
            if (accept || start_pending) begin
                tmr.timer_value <= load_value;
            end
            if (accept) begin
                state      <= next_state;
                main_light <= main_of(next_state);
                side_light <= side_of(next_state);
                walk_lamp  <= (next_state == WALK);
            end
            if (accept && state == WALK) begin
                walk_pending <= 1'b0;
            end else if (walk_request && state != WALK) begin
                walk_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: scenario tests plus a
// randomized run against a phase-table reference model.
module tb_traffic_light_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sensor = 1'b0;
    logic       walk_request = 1'b0;
    logic       prog_en = 1'b0;
    logic [1:0] prog_sel = 2'b00;
    logic [3:0] prog_value = 4'd0;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk_lamp;
    logic [2:0] state_dbg;

    traffic_light_fsm_if tif();

    traffic_light_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .sensor       (sensor),
        .walk_request (walk_request),
        .prog_en      (prog_en),
        .prog_sel     (prog_sel),
        .prog_value   (prog_value),
        .tmr          (tif),
        .main_light   (main_light),
        .side_light   (side_light),
        .walk_lamp    (walk_lamp),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Phase numbering follows the published state_dbg codes.
    localparam int MG1 = 0, MG2 = 1, MY = 2, WK = 3;
    localparam int SG1 = 4, SG2 = 5, SY = 6;

    logic [2:0] lamp_m [7] = '{3'b001, 3'b001, 3'b010, 3'b100,
                               3'b100, 3'b100, 3'b100};
    logic [2:0] lamp_s [7] = '{3'b100, 3'b100, 3'b100, 3'b100,
                               3'b001, 3'b001, 3'b010};

    int ph, p_base, p_ext, p_yel, e_val;
    bit pend, e_start, spend, g2ext;

    function automatic int next_phase(int p, bit s, bit w);
        case (p)
            MG1:     return MG2;
            MG2:     return MY;
            MY:      return w ? WK : SG1;
            WK:      return SG1;
            SG1:     return s ? SG2 : SY;
            SG2:     return SY;
            default: return MG1;
        endcase
    endfunction

    function automatic int interval_of(int p);
        case (p)
            MG2:      return g2ext ? p_ext : p_base;
            MY, SY:   return p_yel;
            WK, SG2:  return p_ext;
            default:  return p_base;
        endcase
    endfunction

    // Reference model: one update per clock from the sampled inputs.
    always @(posedge clk) begin
        bit acc;
        int np;
        int cl;
        if (reset) begin
            ph = MG1; p_base = 6; p_ext = 3; p_yel = 2;
            pend = 0; e_start = 0; e_val = 6; spend = 1; g2ext = 0;
        end else begin
            acc = (tif.timer_expired === 1'b1) && !e_start && !spend;
            np = ph;
            if (acc) begin
                np = next_phase(ph, sensor, pend);
                if (ph == MG1) g2ext = sensor;
                e_val = interval_of(np);
            end else if (spend) begin
                e_val = p_base;
            end
            if (acc && ph == WK) pend = 0;
            else if (walk_request && ph != WK) pend = 1;
            if (prog_en) begin
                cl = (prog_value == 4'd0) ? 1 : int'(prog_value);
                case (prog_sel)
                    2'd0: p_base = cl;
                    2'd1: p_ext = cl;
                    2'd2: p_yel = cl;
                    default: ;
                endcase
            end
            e_start = acc || spend;
            spend = 0;
            ph = np;
        end
    end

    // Timer emulation and start-pulse log.
    int cd = 0;
    bit force_exp = 0;
    int q_val[$];
    int q_state[$];
    logic [2:0] q_main[$];
    logic [2:0] q_side[$];
    bit q_walk[$];

    task automatic clear_log();
        q_val.delete(); q_state.delete(); q_main.delete();
        q_side.delete(); q_walk.delete();
    endtask

    task automatic step();
        bit fire;
        fire = 1'b0;
        if (reset) cd = 0;
        else if (cd > 0) begin
            cd--;
            fire = (cd == 0);
        end
        tif.timer_expired = fire | force_exp;
        @(posedge clk);
        #1;
        if (tif.start_timer === 1'b1) begin
            cd = int'(tif.timer_value) + 1;
            q_val.push_back(int'(tif.timer_value));
            q_state.push_back(int'(state_dbg));
            q_main.push_back(main_light);
            q_side.push_back(side_light);
            q_walk.push_back(walk_lamp);
        end
    endtask

    task automatic do_reset();
        reset = 1; sensor = 0; walk_request = 0;
        prog_en = 0; force_exp = 0;
        step(); step();
        reset = 0;
        clear_log();
    endtask

    task automatic run_starts(int n, int budget, string tag);
        int k;
        k = 0;
        while (q_val.size() < n && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (q_val.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d starts, want %0d",
                     tag, q_val.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        tif.timer_expired = 0;
        step(); step();
        checks += 6;
        if (state_dbg !== 3'd0) begin errors++;
            $display("FAIL rst_state: got %0d want 0", state_dbg); end
        if (main_light !== 3'b001) begin errors++;
            $display("FAIL rst_main: got %b want 001", main_light); end
        if (side_light !== 3'b100) begin errors++;
            $display("FAIL rst_side: got %b want 100", side_light); end
        if (walk_lamp !== 1'b0) begin errors++;
            $display("FAIL rst_walk: got %b want 0", walk_lamp); end
        if (tif.start_timer !== 1'b0) begin errors++;
            $display("FAIL rst_start: got %b want 0", tif.start_timer); end
        if (tif.timer_value !== 4'd6) begin errors++;
            $display("FAIL rst_value: got %0d want 6", tif.timer_value); end
        reset = 0;
        clear_log();
        step();
        checks += 2;
        if (tif.start_timer !== 1'b1) begin errors++;
            $display("FAIL rel_start: got %b want 1", tif.start_timer); end
        if (tif.timer_value !== 4'd6) begin errors++;
            $display("FAIL rel_value: got %0d want 6", tif.timer_value); end
    endtask

    task automatic test_default_cycle();
        int ev[5] = '{6, 6, 2, 6, 2};
        logic [2:0] em[5] = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b100};
        logic [2:0] es[5] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010};
        do_reset();
        run_starts(10, 500, "default");
        for (int i = 0; i < 10; i++) begin
            if (i < q_val.size()) begin
                checks += 3;
                if (q_val[i] !== ev[i % 5]) begin errors++;
                    $display("FAIL default_val[%0d]: got %0d want %0d",
                             i, q_val[i], ev[i % 5]); end
                if (q_main[i] !== em[i % 5]) begin errors++;
                    $display("FAIL default_main[%0d]: got %b want %b",
                             i, q_main[i], em[i % 5]); end
                if (q_side[i] !== es[i % 5]) begin errors++;
                    $display("FAIL default_side[%0d]: got %b want %b",
                             i, q_side[i], es[i % 5]); end
            end
        end
    endtask

    task automatic test_sensor();
        int ev[6] = '{6, 3, 2, 6, 3, 2};
        int es[6] = '{0, 1, 2, 4, 5, 6};
        do_reset();
        sensor = 1;
        run_starts(6, 500, "sensor");
        for (int i = 0; i < 6; i++) begin
            if (i < q_val.size()) begin
                checks += 2;
                if (q_val[i] !== ev[i]) begin errors++;
                    $display("FAIL sensor_val[%0d]: got %0d want %0d",
                             i, q_val[i], ev[i]); end
                if (q_state[i] !== es[i]) begin errors++;
                    $display("FAIL sensor_state[%0d]: got %0d want %0d",
                             i, q_state[i], es[i]); end
            end
        end
        sensor = 0;
    endtask

    task automatic test_walk();
        int ev[10] = '{6, 6, 2, 3, 6, 2, 6, 6, 2, 6};
        int es[10] = '{0, 1, 2, 3, 4, 6, 0, 1, 2, 4};
        bit pulsed;
        int k;
        do_reset();
        step();
        walk_request = 1;
        step();
        walk_request = 0;
        pulsed = 0;
        k = 0;
        while (q_val.size() < 10 && k < 600) begin
            if (state_dbg === 3'd3 && !pulsed) begin
                walk_request = 1;
                pulsed = 1;
            end
            step();
            walk_request = 0;
            k++;
        end
        checks++;
        if (q_val.size() < 10) begin errors++;
            $display("FAIL walk_timeout: got %0d starts want 10",
                     q_val.size()); end
        for (int i = 0; i < 10; i++) begin
            if (i < q_val.size()) begin
                checks += 3;
                if (q_val[i] !== ev[i]) begin errors++;
                    $display("FAIL walk_val[%0d]: got %0d want %0d",
                             i, q_val[i], ev[i]); end
                if (q_state[i] !== es[i]) begin errors++;
                    $display("FAIL walk_state[%0d]: got %0d want %0d",
                             i, q_state[i], es[i]); end
                if (q_walk[i] !== (es[i] == 3)) begin errors++;
                    $display("FAIL walk_lamp[%0d]: got %b want %b",
                             i, q_walk[i], (es[i] == 3)); end
            end
        end
        if (q_val.size() > 3) begin
            checks += 2;
            if (q_main[3] !== 3'b100) begin errors++;
                $display("FAIL walk_main: got %b want 100", q_main[3]); end
            if (q_side[3] !== 3'b100) begin errors++;
                $display("FAIL walk_side: got %b want 100", q_side[3]); end
        end
    endtask

    task automatic test_prog();
        int ev[8] = '{6, 4, 1, 4, 1, 4, 4, 1};
        do_reset();
        step();
        prog_en = 1; prog_sel = 2'b00; prog_value = 4'd4;
        step();
        checks += 2;
        if (tif.timer_value !== 4'd6) begin errors++;
            $display("FAIL prog_running: got %0d want 6", tif.timer_value); end
        if (state_dbg !== 3'd0) begin errors++;
            $display("FAIL prog_state: got %0d want 0", state_dbg); end
        prog_sel = 2'b10; prog_value = 4'd0;
        step();
        prog_sel = 2'b11; prog_value = 4'd9;
        step();
        prog_en = 0;
        run_starts(8, 500, "prog");
        for (int i = 0; i < 8; i++) begin
            if (i < q_val.size()) begin
                checks++;
                if (q_val[i] !== ev[i]) begin errors++;
                    $display("FAIL prog_val[%0d]: got %0d want %0d",
                             i, q_val[i], ev[i]); end
            end
        end
    endtask

    task automatic test_expire_with_start();
        do_reset();
        step();
        force_exp = 1;
        step();
        force_exp = 0;
        checks += 2;
        if (state_dbg !== 3'd0) begin errors++;
            $display("FAIL exp_start_state: got %0d want 0", state_dbg); end
        if (tif.start_timer !== 1'b0) begin errors++;
            $display("FAIL exp_start_pulse: got %b want 0",
                     tif.start_timer); end
        run_starts(2, 100, "exp_start");
        if (q_val.size() > 1) begin
            checks++;
            if (q_state[1] !== 1) begin errors++;
                $display("FAIL exp_start_next: got %0d want 1",
                         q_state[1]); end
        end
    endtask

    task automatic test_reset_mid();
        int es[5] = '{0, 1, 2, 4, 6};
        int k;
        do_reset();
        sensor = 1;
        k = 0;
        while (state_dbg !== 3'd5 && k < 300) begin
            step();
            k++;
        end
        checks++;
        if (state_dbg !== 3'd5) begin errors++;
            $display("FAIL mid_reach: got %0d want 5", state_dbg); end
        walk_request = 1;
        step();
        walk_request = 0;
        reset = 1;
        step();
        checks += 4;
        if (state_dbg !== 3'd0) begin errors++;
            $display("FAIL mid_state: got %0d want 0", state_dbg); end
        if (main_light !== 3'b001) begin errors++;
            $display("FAIL mid_main: got %b want 001", main_light); end
        if (side_light !== 3'b100) begin errors++;
            $display("FAIL mid_side: got %b want 100", side_light); end
        if (tif.start_timer !== 1'b0) begin errors++;
            $display("FAIL mid_start: got %b want 0", tif.start_timer); end
        reset = 0;
        sensor = 0;
        clear_log();
        step();
        checks += 2;
        if (tif.start_timer !== 1'b1) begin errors++;
            $display("FAIL mid_rel_start: got %b want 1", tif.start_timer); end
        if (tif.timer_value !== 4'd6) begin errors++;
            $display("FAIL mid_rel_value: got %0d want 6", tif.timer_value); end
        run_starts(5, 300, "mid");
        for (int i = 0; i < 5; i++) begin
            if (i < q_state.size()) begin
                checks++;
                if (q_state[i] !== es[i]) begin errors++;
                    $display("FAIL mid_seq[%0d]: got %0d want %0d",
                             i, q_state[i], es[i]); end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(19, 0) == 0) sensor = ~sensor;
            walk_request = ($urandom_range(9, 0) == 0);
            prog_en = ($urandom_range(11, 0) == 0);
            prog_sel = 2'($urandom_range(3, 0));
            prog_value = 4'($urandom_range(15, 0));
            reset = ($urandom_range(399, 0) == 0);
            force_exp = !reset && (tif.start_timer === 1'b1)
                        && ($urandom_range(2, 0) == 0);
            step();
            force_exp = 0;
            checks += 5;
            if (state_dbg !== 3'(ph)) begin errors++;
                $display("FAIL rnd_state@%0d: got %0d want %0d",
                         n, state_dbg, ph); end
            if (main_light !== lamp_m[ph]) begin errors++;
                $display("FAIL rnd_main@%0d: got %b want %b",
                         n, main_light, lamp_m[ph]); end
            if (side_light !== lamp_s[ph]) begin errors++;
                $display("FAIL rnd_side@%0d: got %b want %b",
                         n, side_light, lamp_s[ph]); end
            if (walk_lamp !== (ph == WK)) begin errors++;
                $display("FAIL rnd_walk@%0d: got %b want %b",
                         n, walk_lamp, (ph == WK)); end
            if (tif.start_timer !== e_start) begin errors++;
                $display("FAIL rnd_start@%0d: got %b want %b",
                         n, tif.start_timer, e_start); end
            if (e_start) begin
                checks++;
                if (tif.timer_value !== 4'(e_val)) begin errors++;
                    $display("FAIL rnd_value@%0d: got %0d want %0d",
                             n, tif.timer_value, e_val); end
            end
        end
        reset = 0;
        walk_request = 0;
        prog_en = 0;
    endtask

    initial begin
        tif.timer_expired = 1'b0;
        test_reset();
        test_default_cycle();
        test_sensor();
        test_walk();
        test_prog();
        test_expire_with_start();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Sequencing controller for the intersection's interval timer (4-bit seconds countdown with `value_input`, `startTimer` and a one-cycle `expired` pulse).
- Holds three programmable interval parameters: BASE, EXT and YEL.
- Selects which interval to load and pulses the timer start on every state entry.
- Advances main/side lights and the walk lamp when the timer expires, reacting to the side-street sensor and a latched pedestrian request.

Parameters:
- BASE_DEFAULT, 4'd6, BASE interval in seconds loaded at reset.
- EXT_DEFAULT, 4'd3, EXT interval in seconds loaded at reset.
- YEL_DEFAULT, 4'd2, YEL interval in seconds loaded at reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- sensor  in  1  side-street vehicle present (level).
- walk_request  in  1  pedestrian button (single-cycle pulse, pre-synchronised).
- prog_en  in  1  write strobe for an interval parameter.
- prog_sel  in  2  00=BASE, 01=EXT, 10=YEL; 11=no-op.
- prog_value  in  4  new interval value in seconds.
- timer_expired  in  1  one-cycle expiry pulse from the timer.
- start_timer  out  1  one-cycle load/start pulse to the timer.
- timer_value  out  4  interval for the timer; valid whenever start_timer=1.
- main_light  out  3  {red,yellow,green}, one-hot.
- side_light  out  3  {red,yellow,green}, one-hot.
- walk_lamp  out  1  pedestrian walk indicator.
- state_dbg  out  3  current state encoding.

Behaviour:
- All outputs are registered.
- Reset is synchronous, active-high; clock clk.
- Values during reset:
  - state=MAIN_G1, parameters = defaults, walk_pending=0.
  - main_light=001, side_light=100, walk_lamp=0.
  - start_timer=0, timer_value=BASE_DEFAULT.
  - start_pending=1, so start_timer=1 in the first cycle after reset deasserts.
- Entry rule:
  - A transition taken in cycle t makes the new state, lights and timer_value visible in cycle t+1.
  - start_timer=1 for exactly cycle t+1; it is never asserted in two consecutive cycles.
- timer_expired is ignored in any cycle where start_timer=1.
- States (lights shown as main/side; load = interval loaded on entry):
  - MAIN_G1: green/red; load BASE. On expiry: sensor=1 → MAIN_G2 loading EXT; sensor=0 → MAIN_G2 loading BASE.
  - MAIN_G2: green/red; load as selected above. On expiry → MAIN_Y.
  - MAIN_Y: yellow/red; load YEL. On expiry: walk_pending=1 → WALK; else → SIDE_G1.
  - WALK: red/red, walk_lamp=1; load EXT. On expiry → SIDE_G1 and walk_pending cleared.
  - SIDE_G1: red/green; load BASE. On expiry: sensor=1 → SIDE_G2; sensor=0 → SIDE_Y.
  - SIDE_G2: red/green; load EXT. On expiry → SIDE_Y.
  - SIDE_Y: red/yellow; load YEL. On expiry → MAIN_G1.
- sensor is sampled only in the cycle timer_expired is accepted.
- walk_pending:
  - Set by walk_request in any state except WALK.
  - Requests arriving during WALK are dropped.
  - Clear on WALK exit has priority.
  - Multiple requests collapse to one.
- Parameter writes:
  - A write with prog_en=1 updates the selected register next cycle.
  - prog_value=0 is stored as 1 (avoids a 16 s wrap).
  - prog_sel=11 is ignored.
  - A write in the same cycle as a load does not affect that load (old value used).
  - A running interval is never altered.
- Reset mid-interval aborts immediately to the reset state; walk_pending is lost.
- Lights are always decoded from state; exactly one lamp per street is lit. Both greens are never lit together.

Decomposition:
- Package tl_pkg:
  - State encodings: MAIN_G1=0 … SIDE_Y=6.
  - Interval select codes SEL_BASE=00, SEL_EXT=01, SEL_YEL=10.
  - Light constants RED=100, YEL=010, GRN=001.
- Sub-module tl_param_regs:
  - Holds the three 4-bit registers with defaults and zero-clamp.
  - Takes a select input; drives the selected value combinationally.
- The FSM top registers the value alongside start_timer.

Test Plan:
- Reset, sensor=0, no walk, defaults:
  - start_timer pulses with values 6, 6, 2, 6, 2, repeating.
  - main_light sequence: 001, 001, 010, 100, 100.
  - side_light: 100 until SIDE_G1 (001), then SIDE_Y (010).
- sensor=1 held: MAIN_G2 loads 3; SIDE_G2 entered, loads 3; full cycle is 6, 3, 2, 6, 3, 2.
- walk_request pulsed during MAIN_G1:
  - After MAIN_Y expiry → WALK with both lights 100, walk_lamp=1, load 3.
  - Then SIDE_G1.
  - A second request during WALK produces no further WALK phase.
- prog_en with sel=00, value=4 during MAIN_G1:
  - Current interval is unchanged.
  - The next BASE load shows timer_value=4.
  - Writing value=0 to YEL gives a next YEL load of 1.
  - Writing with sel=11 changes nothing.
- timer_expired asserted in the same cycle as start_timer: ignored, state unchanged.
- Reset asserted mid-SIDE_G2 with walk pending:
  - Next cycle: state_dbg=0, main 001, side 100, walk_pending=0.
  - start_timer=1 with value 6 one cycle after reset releases.
